// File: rtl/cmem_pkg.sv
// Shared constants and types for the layer-memory arbiter.
package cmem_pkg;

    localparam int unsigned NREQ = 3;   // conv, relu, pool engines
    localparam int unsigned AW   = 12;  // layer-memory address width
    localparam int unsigned DW   = 20;  // signed Q4.16 data
    localparam int unsigned SELW = 3;   // memory select width

    localparam logic [SELW-1:0] CSEL_NONE = 3'b000;
    localparam logic [SELW-1:0] CSEL_L0   = 3'b001;
    localparam logic [SELW-1:0] CSEL_L1   = 3'b011;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

endpackage

// File: rtl/cmem_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping to 0.
module rr_pick
    import cmem_pkg::*;
#(
    parameter int unsigned N  = NREQ,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    int unsigned idx;
    logic        found;

    // Scan N positions starting at ptr; the first asserted request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmem_arbiter.sv
// Layer-memory arbiter: round-robin grant with burst lock, registered
// memory strobes and a two-cycle tagged read-return pipeline.
module cmem_arbiter
    import cmem_pkg::*;
#(
    parameter int unsigned NREQ = cmem_pkg::NREQ,
    parameter int unsigned AW   = cmem_pkg::AW,
    parameter int unsigned DW   = cmem_pkg::DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [SELW*NREQ-1:0] sel,
    input  logic [AW*NREQ-1:0]   addr,
    input  logic [DW*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 cwr,
    output logic                 crd,
    output logic [SELW-1:0]      csel,
    output logic [AW-1:0]        caddr_wr,
    output logic [AW-1:0]        caddr_rd,
    output logic [DW-1:0]        cdata_wr,
    input  logic [DW-1:0]        cdata_rd
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] rr_gnt;
    logic [NREQ-1:0] gnt_c;
    logic [PW-1:0]   gidx;
    logic            g_any;
    logic            g_we;
    logic            g_lock;
    logic            owner_hold;
    logic [SELW-1:0] g_sel;
    logic [AW-1:0]   g_addr;
    logic [DW-1:0]   g_wdata;

    logic            cwr_q, crd_q;
    logic [SELW-1:0] csel_q;
    logic [AW-1:0]   caddr_wr_q, caddr_rd_q;
    logic [DW-1:0]   cdata_wr_q;
    logic [NREQ-1:0] rd_pend_q;
    logic [NREQ-1:0] rvalid_q;
    logic [DW-1:0]   rdata_q;

    rr_pick #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    // Grant selection, granted-request mux and next-state for ptr/FSM.
    // A dropped lock releases immediately, so the round-robin result is
    // used in the very cycle the owner lets go.
    always_comb begin
        owner_hold = (state_q == LOCKED) && req[owner_q] && lock[owner_q];
        gnt_c      = '0;
        if (owner_hold) begin
            gnt_c[owner_q] = 1'b1;
        end else begin
            gnt_c = rr_gnt;
        end

        g_any = |gnt_c;
        gidx  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) begin
                gidx = PW'(i);
            end
        end

        g_we    = we[gidx];
        g_lock  = lock[gidx];
        g_sel   = sel[32'(gidx)*SELW +: SELW];
        g_addr  = addr[32'(gidx)*AW +: AW];
        g_wdata = wdata[32'(gidx)*DW +: DW];

        ptr_d = ptr_q;
        if (g_any && !owner_hold) begin
            ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end

        state_d = IDLE;
        owner_d = owner_q;
        if (g_any && g_lock) begin
            state_d = LOCKED;
            owner_d = gidx;
        end
    end

    // Arbitration state: lock owner, FSM state and round-robin pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Memory-side strobes one cycle after grant; read data returns one
    // cycle later still, tagged by the one-hot grant held in rd_pend_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= CSEL_NONE;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            rd_pend_q  <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            rvalid_q <= rd_pend_q;
            rdata_q  <= crd_q ? cdata_rd : '0;
            if (g_any) begin
                csel_q    <= g_sel;
                cwr_q     <= g_we && (g_sel != CSEL_NONE);
                crd_q     <= !g_we && (g_sel != CSEL_NONE);
                rd_pend_q <= g_we ? '0 : gnt_c;
                if (g_we) begin
                    caddr_wr_q <= g_addr;
                    cdata_wr_q <= g_wdata;
                end else begin
                    caddr_rd_q <= g_addr;
                end
            end else begin
                csel_q    <= CSEL_NONE;
                cwr_q     <= 1'b0;
                crd_q     <= 1'b0;
                rd_pend_q <= '0;
            end
        end
    end

    assign gnt      = gnt_c;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign csel     = csel_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_cmem_arbiter.sv
// Directed bench for cmem_arbiter with a per-cycle expectation scoreboard.
module tb_cmem_arbiter;
    import cmem_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      lock = '0;
    logic [NREQ-1:0]      we = '0;
    logic [SELW*NREQ-1:0] sel = '0;
    logic [AW*NREQ-1:0]   addr = '0;
    logic [DW*NREQ-1:0]   wdata = '0;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [DW-1:0]        rdata, cdata_wr, cdata_rd;
    logic                 cwr, crd;
    logic [SELW-1:0]      csel;
    logic [AW-1:0]        caddr_wr, caddr_rd;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic            cwr;
        logic            crd;
        logic [SELW-1:0] csel;
        logic [AW-1:0]   aw;
        logic [AW-1:0]   ar;
        logic [DW-1:0]   dw;
    } mem_exp_t;

    typedef struct {
        logic [NREQ-1:0] rv;
        logic [DW-1:0]   rd;
    } rd_exp_t;

    mem_exp_t mem_q[$];
    rd_exp_t  rd_q[$];
    logic [AW-1:0] sh_aw = '0;
    logic [AW-1:0] sh_ar = '0;
    logic [DW-1:0] sh_dw = '0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 12'hFFF) return 20'h1A2B3;
        return {a[7:0], a};
    endfunction

    // Memory model: data only meaningful while crd is high.
    always_comb cdata_rd = crd ? mem_fn(caddr_rd) : '1;

    cmem_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .lock     (lock),
        .we       (we),
        .sel      (sel),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .cwr      (cwr),
        .crd      (crd),
        .csel     (csel),
        .caddr_wr (caddr_wr),
        .caddr_rd (caddr_rd),
        .cdata_wr (cdata_wr),
        .cdata_rd (cdata_rd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int unsigned k, input logic w, input logic [SELW-1:0] s,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[k]                = w;
        sel[k*SELW +: SELW]  = s;
        addr[k*AW +: AW]     = a;
        wdata[k*DW +: DW]    = d;
    endtask

    task automatic check_outputs(input string tag);
        mem_exp_t me;
        rd_exp_t  re;
        me = mem_q.pop_front();
        chk({tag, ".cwr"}, 32'(cwr), 32'(me.cwr));
        chk({tag, ".crd"}, 32'(crd), 32'(me.crd));
        chk({tag, ".csel"}, 32'(csel), 32'(me.csel));
        chk({tag, ".caddr_wr"}, 32'(caddr_wr), 32'(me.aw));
        chk({tag, ".caddr_rd"}, 32'(caddr_rd), 32'(me.ar));
        chk({tag, ".cdata_wr"}, 32'(cdata_wr), 32'(me.dw));
        if (rd_q.size() > 1) begin
            re = rd_q.pop_front();
            chk({tag, ".rvalid"}, 32'(rvalid), 32'(re.rv));
            if (re.rv != '0) chk({tag, ".rdata"}, 32'(rdata), 32'(re.rd));
        end
    endtask

    // One clock cycle: drive req/lock, check combinational grant, queue
    // what the memory side and read return must show later.
    task automatic cyc(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic [NREQ-1:0] exp_gnt, input string tag);
        mem_exp_t        me;
        rd_exp_t         re;
        int unsigned     k;
        logic [SELW-1:0] s;
        logic [AW-1:0]   a;
        logic [DW-1:0]   d;
        req  = r;
        lock = l;
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'(exp_gnt));
        me = '{cwr: 1'b0, crd: 1'b0, csel: CSEL_NONE, aw: sh_aw, ar: sh_ar, dw: sh_dw};
        re = '{rv: '0, rd: '0};
        if (exp_gnt != '0) begin
            k = 0;
            for (int unsigned i = 0; i < NREQ; i++) if (exp_gnt[i]) k = i;
            s = sel[k*SELW +: SELW];
            a = addr[k*AW +: AW];
            d = wdata[k*DW +: DW];
            me.csel = s;
            if (we[k]) begin
                me.cwr = (s != CSEL_NONE);
                sh_aw = a;
                sh_dw = d;
                me.aw = a;
                me.dw = d;
            end else begin
                me.crd = (s != CSEL_NONE);
                sh_ar = a;
                me.ar = a;
                re.rv = exp_gnt;
                re.rd = (s != CSEL_NONE) ? mem_fn(a) : '0;
            end
        end
        mem_q.push_back(me);
        rd_q.push_back(re);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        cyc('0, '0, '0, tag);
    endtask

    // Assert reset at the current negedge, check every output cleared,
    // then release and drain two idle cycles.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        #1;
        chk({tag, ".gnt"}, 32'(gnt), 32'd0);
        chk({tag, ".rvalid"}, 32'(rvalid), 32'd0);
        chk({tag, ".rdata"}, 32'(rdata), 32'd0);
        chk({tag, ".cwr"}, 32'(cwr), 32'd0);
        chk({tag, ".crd"}, 32'(crd), 32'd0);
        chk({tag, ".csel"}, 32'(csel), 32'd0);
        chk({tag, ".caddr_wr"}, 32'(caddr_wr), 32'd0);
        chk({tag, ".caddr_rd"}, 32'(caddr_rd), 32'd0);
        chk({tag, ".cdata_wr"}, 32'(cdata_wr), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".rvalid_hold"}, 32'(rvalid), 32'd0);
        reset = 1'b0;
        mem_q.delete();
        rd_q.delete();
        sh_aw = '0;
        sh_ar = '0;
        sh_dw = '0;
        idle({tag, ".i0"});
        idle({tag, ".i1"});
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        // Round-robin rotation with pipelined reads from all three.
        set_port(0, 1'b0, CSEL_L0, 12'h010, '0);
        set_port(1, 1'b0, CSEL_L1, 12'h021, '0);
        set_port(2, 1'b0, CSEL_L0, 12'h032, '0);
        cyc(3'b111, 3'b000, 3'b001, "rr0");
        cyc(3'b111, 3'b000, 3'b010, "rr1");
        cyc(3'b111, 3'b000, 3'b100, "rr2");
        cyc(3'b111, 3'b000, 3'b001, "rr3");
        idle("rr.d0");
        idle("rr.d1");

        // Single read at the top address.
        set_port(0, 1'b0, CSEL_L0, 12'hFFF, '0);
        cyc(3'b001, 3'b000, 3'b001, "rd0");
        idle("rd0.d0");
        idle("rd0.d1");

        // Write with no target: no strobe.
        set_port(0, 1'b1, CSEL_NONE, 12'h055, 20'hABCDE);
        cyc(3'b001, 3'b000, 3'b001, "wr_none");
        idle("wr_none.d0");

        // Requester 1 write to L1.
        set_port(1, 1'b1, CSEL_L1, 12'h3FF, 20'h00123);
        cyc(3'b010, 3'b000, 3'b010, "wr1");
        idle("wr1.d0");

        // Requester 2 locked burst of four reads against full contention.
        set_port(0, 1'b0, CSEL_L0, 12'h044, '0);
        set_port(1, 1'b0, CSEL_L1, 12'h066, '0);
        for (int unsigned j = 0; j < 4; j++) begin
            set_port(2, 1'b0, CSEL_L0, 12'h100 + 12'(j), '0);
            cyc(3'b111, 3'b100, 3'b100, $sformatf("lk%0d", j));
        end
        cyc(3'b111, 3'b000, 3'b001, "release");
        cyc(3'b111, 3'b000, 3'b010, "post_rel");
        cyc(3'b011, 3'b000, 3'b001, "wrap");
        idle("lk.d0");
        idle("lk.d1");

        // Read with no target still returns rvalid with zero data.
        set_port(1, 1'b0, CSEL_NONE, 12'h077, '0);
        cyc(3'b010, 3'b000, 3'b010, "rd_none");
        idle("rd_none.d0");
        idle("rd_none.d1");

        // Reset the cycle after a read grant: read is dropped, ptr back to 0.
        set_port(0, 1'b0, CSEL_L0, 12'h0AB, '0);
        cyc(3'b001, 3'b000, 3'b001, "rd_rst");
        do_reset("rst1");
        cyc(3'b111, 3'b000, 3'b001, "post_rst1");
        idle("post_rst1.d0");
        idle("post_rst1.d1");

        // Reset in the middle of a locked burst clears the lock.
        cyc(3'b010, 3'b010, 3'b010, "lkb0");
        cyc(3'b111, 3'b010, 3'b010, "lkb1");
        do_reset("rst2");
        cyc(3'b111, 3'b000, 3'b001, "post_rst2");
        idle("post_rst2.d0");
        idle("post_rst2.d1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
